// File: rtl/mpls_switch_conditioner.sv
// Switch front end for the LED sequencer: synchronises the raw 6-bit switch word,
// debounces it as a unit and presents glitch-free committed settings plus an update strobe.
module mpls_switch_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 10000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk_10MHz,
    input  logic       rstn,
    input  logic [5:0] sw_in,
    output logic [1:0] clk_selector,
    output logic [3:0] pattern_sel,
    output logic       cfg_update,
    output logic       cfg_busy
);

    localparam int unsigned WORD_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][WORD_W-1:0] sync_q;
    logic [WORD_W-1:0]                  sync_word;
    state_t                             state_q;
    logic [WORD_W-1:0]                  cand_q;
    logic [WORD_W-1:0]                  committed_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic                               update_q;
    logic                               busy_q;

    // Only the first stage of this chain ever looks at the raw switches.
    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign sync_word = sync_q[SYNC_STAGES-1];

    // Debounce FSM; update/busy flops are loaded with the decode of the next state.
    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            committed_q <= '0;
            cnt_q       <= '0;
            update_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_word != committed_q) begin
                        cand_q  <= sync_word;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                        busy_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    busy_q <= 1'b1;
                    if (sync_word != cand_q) begin
                        cand_q <= sync_word;
                        cnt_q  <= '0;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        busy_q <= 1'b0;
                        if (cand_q != committed_q) begin
                            committed_q <= cand_q;
                            state_q     <= COMMIT;
                            update_q    <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign clk_selector = committed_q[1:0];
    assign pattern_sel  = committed_q[5:2];
    assign cfg_update   = update_q;
    assign cfg_busy     = busy_q;

endmodule
